// File: rtl/route_dist_pipe.sv
// route_dist_pipe: two-stage channel-to-capacitor router with a double-buffered route table and saturation-run flags
module route_dist_pipe #(
  parameter int WIDTH     = 8,
  parameter int CH_NUM    = 4,
  parameter int CAP_NUM   = 8,
  parameter int SAT_CNT_W = 8,
  parameter int SEL_W     = $clog2(CH_NUM + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [WIDTH*CH_NUM-1:0]      data_in,
  input  logic                         cfg_we,
  input  logic [$clog2(CAP_NUM)-1:0]   cfg_addr,
  input  logic [SEL_W-1:0]             cfg_sel,
  input  logic                         cfg_commit,
  input  logic [SAT_CNT_W-1:0]         sat_thresh,
  output logic                         cfg_pending,
  output logic                         out_valid,
  output logic [WIDTH*CAP_NUM-1:0]     data_out,
  output logic [CAP_NUM-1:0]           sat_flag
);
  logic [WIDTH*CH_NUM-1:0]  data_q;
  logic                     v1_q, out_valid_q, pending_q, pending_d, apply;
  logic [SEL_W-1:0]         shadow_q [CAP_NUM];
  logic [SEL_W-1:0]         shadow_d [CAP_NUM];
  logic [SEL_W-1:0]         active_q [CAP_NUM];
  logic [SEL_W-1:0]         active_d [CAP_NUM];
  logic [WIDTH-1:0]         route    [CAP_NUM];
  logic [CAP_NUM-1:0]       conn;
  logic [SAT_CNT_W-1:0]     cnt_q    [CAP_NUM];
  logic [SAT_CNT_W-1:0]     cnt_d    [CAP_NUM];
  logic [CAP_NUM-1:0]       flag_q, flag_d;
  logic [WIDTH*CAP_NUM-1:0] dout_q, dout_d;
  // The table only swaps when neither stage holds a sample, so no sample straddles two tables
  always_comb begin
    apply     = (cfg_commit | pending_q) & ~in_valid & ~v1_q;
    pending_d = apply ? 1'b0 : (cfg_commit | pending_q);
    dout_d    = '0;
    flag_d    = flag_q;
    for (int j = 0; j < CAP_NUM; j++) begin
      shadow_d[j] = (cfg_we && 32'(cfg_addr) == j) ? cfg_sel : shadow_q[j];
      active_d[j] = apply ? shadow_d[j] : active_q[j];
      route[j]    = '0;
      for (int k = 0; k < CH_NUM; k++)
        if (32'(active_q[j]) == k) route[j] = data_q[k*WIDTH +: WIDTH];
      conn[j]     = 32'(active_q[j]) < CH_NUM;
      dout_d[j*WIDTH +: WIDTH] = route[j];
      cnt_d[j]    = !v1_q ? cnt_q[j] :
                    (conn[j] && (route[j] == '0 || route[j] == '1)) ?
                    ((cnt_q[j] == '1) ? cnt_q[j] : cnt_q[j] + 1'b1) : '0;
      flag_d[j]   = v1_q ? (sat_thresh != '0 && cnt_d[j] >= sat_thresh) : flag_q[j];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q      <= '0;
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      pending_q   <= 1'b0;
      dout_q      <= '0;
      flag_q      <= '0;
      for (int j = 0; j < CAP_NUM; j++) begin
        shadow_q[j] <= SEL_W'(j % CH_NUM);
        active_q[j] <= SEL_W'(j % CH_NUM);
        cnt_q[j]    <= '0;
      end
    end else begin
      data_q      <= data_in;
      v1_q        <= in_valid;
      out_valid_q <= v1_q;
      pending_q   <= pending_d;
      dout_q      <= dout_d;
      flag_q      <= flag_d;
      for (int j = 0; j < CAP_NUM; j++) begin
        shadow_q[j] <= shadow_d[j];
        active_q[j] <= active_d[j];
        cnt_q[j]    <= cnt_d[j];
      end
    end
  end
  assign cfg_pending = pending_q;
  assign out_valid   = out_valid_q;
  assign data_out    = dout_q;
  assign sat_flag    = flag_q;
endmodule

// File: tb/tb_route_dist_pipe.sv
// tb_route_dist_pipe: directed and random stimulus against a sample-level reference model of route_dist_pipe
module tb_route_dist_pipe;
  localparam int W = 8, CH = 4, CAP = 8, SCW = 2, SW = 3;
  localparam int CMAX = 2**SCW - 1;
  logic clk = 0, rst = 1, in_valid = 0, cfg_we = 0, cfg_commit = 0;
  logic [W*CH-1:0]  data_in = '0;
  logic [2:0]       cfg_addr = '0;
  logic [SW-1:0]    cfg_sel = '0;
  logic [SCW-1:0]   sat_thresh = '0;
  logic             cfg_pending, out_valid;
  logic [W*CAP-1:0] data_out;
  logic [CAP-1:0]   sat_flag;
  route_dist_pipe #(.WIDTH(W), .CH_NUM(CH), .CAP_NUM(CAP), .SAT_CNT_W(SCW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_sel(cfg_sel), .cfg_commit(cfg_commit), .sat_thresh(sat_thresh),
    .cfg_pending(cfg_pending), .out_valid(out_valid), .data_out(data_out), .sat_flag(sat_flag)
  );
  always #5 clk = ~clk;
  int nvec = 0, nerr = 0;
  int sh [CAP], act [CAP], cnt [CAP];
  bit pend, mv1, mov;
  logic [W*CH-1:0]  md1;
  logic [W*CAP-1:0] mout;
  logic [CAP-1:0]   mflag;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  // Sample-level model: each sample is routed by whichever table is active when it leaves stage 1
  task automatic model();
    if (rst) begin
      pend = 0; mv1 = 0; mov = 0; md1 = '0; mout = '0; mflag = '0;
      for (int j = 0; j < CAP; j++) begin sh[j] = j % CH; act[j] = j % CH; cnt[j] = 0; end
    end else begin
      for (int j = 0; j < CAP; j++) begin
        int a;
        logic [W-1:0] w;
        a = act[j];
        w = (a < CH) ? md1[a*W +: W] : '0;
        mout[j*W +: W] = w;
        if (mv1) begin
          cnt[j]   = (a < CH && (w == 8'h00 || w == 8'hFF)) ? ((cnt[j] + 1 > CMAX) ? CMAX : cnt[j] + 1) : 0;
          mflag[j] = (sat_thresh != 0) && (cnt[j] >= int'(sat_thresh));
        end
      end
      mov = mv1;
      if (cfg_we) sh[cfg_addr] = cfg_sel;
      if ((cfg_commit || pend) && !in_valid && !mv1) begin
        for (int j = 0; j < CAP; j++) act[j] = sh[j];
        pend = 0;
      end else if (cfg_commit) pend = 1;
      mv1 = in_valid;
      md1 = data_in;
    end
  endtask
  task automatic step();
    @(posedge clk);
    model();
    @(negedge clk);
    chk("pending", cfg_pending, pend);
    chk("out_valid", out_valid, mov);
    if (mov) chk("data_out", data_out, mout);
    chk("sat_flag", sat_flag, mflag);
  endtask
  task automatic drv(input bit v, input logic [31:0] d, input bit we = 0, input int addr = 0,
                     input int sel = 0, input bit cm = 0);
    in_valid = v; data_in = d; cfg_we = we; cfg_addr = addr[2:0]; cfg_sel = sel[SW-1:0]; cfg_commit = cm;
    step();
  endtask
  function automatic logic [W-1:0] rnd_word();
    int r;
    r = $urandom_range(0, 3);
    return (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : W'($urandom);
  endfunction
  initial begin
    rst = 1;
    drv(0, 0);
    drv(0, 0);
    chk("rst_out_valid", out_valid, 0);
    rst = 0;
    drv(0, 0);
    drv(1, 32'h44332211);
    drv(0, 0);
    chk("default_route", data_out, 64'h44332211_44332211);
    drv(0, 0, 1, 0, 3);
    drv(0, 0, 1, 5, 4, 1);
    chk("idle_commit_pending", cfg_pending, 0);
    drv(1, 32'h44332211);
    drv(0, 0);
    chk("reprogrammed_route", data_out, 64'h44330011_44332244);
    for (int i = 0; i < 8; i++) drv(1, $urandom, i == 1, 1, 0, i == 2);
    chk("stream_pending", cfg_pending, 1);
    drv(0, 0);
    chk("one_bubble_pending", cfg_pending, 1);
    drv(0, 0);
    chk("two_bubble_applied", cfg_pending, 0);
    drv(1, 32'h44332211);
    drv(0, 0);
    chk("stream_new_table", data_out[15:8], 8'h11);
    rst = 1;
    drv(0, 0);
    rst = 0;
    sat_thresh = 3;
    for (int i = 0; i < 5; i++) begin
      drv(1, 32'h124578FF);
      drv(0, 0);
      drv(0, 0);
      chk("sat_run", sat_flag[0], i >= 2);
    end
    drv(1, 32'h1245785A);
    drv(0, 0);
    chk("sat_clear", sat_flag[0], 0);
    for (int i = 0; i < 10; i++) drv(1, 0);
    drv(0, 0);
    drv(0, 0);
    chk("cnt_saturated_flags", sat_flag, 8'hFF);
    drv(0, 0, 1, 2, 3);
    drv(1, 32'hA1B2C3D4);
    drv(1, 32'h0F1E2D3C, 0, 0, 0, 1);
    chk("pre_rst_pending", cfg_pending, 1);
    rst = 1;
    drv(1, 32'h55667788, 1, 3, 0);
    rst = 0;
    drv(0, 0);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_pending", cfg_pending, 0);
    drv(1, 32'h44332211);
    drv(0, 0);
    chk("post_rst_default", data_out, 64'h44332211_44332211);
    for (int i = 0; i < 600; i++) begin
      logic [31:0] d;
      for (int c = 0; c < CH; c++) d[c*W +: W] = rnd_word();
      if ($urandom_range(0, 19) == 0) sat_thresh = SCW'($urandom);
      rst = ($urandom_range(0, 59) == 0);
      drv($urandom_range(0, 9) < 6, d, $urandom_range(0, 4) == 0, $urandom_range(0, 7),
          $urandom_range(0, 7), $urandom_range(0, 9) == 0);
    end
    rst = 0;
    drv(0, 0);
    drv(0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
